// File: rtl/riscv_tb_pkg.sv
// Shared types and helpers for the RV32I program self-check sequencer.
package riscv_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_WR,
    ST_LOAD_GAP,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_MISMATCH = 2'd1;
  localparam logic [1:0] FAIL_MISSING  = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd3;

  // Byte address of mailbox word idx.
  function automatic logic [31:0] mbox_addr(input logic [31:0] base, input int idx);
    return base + (32'(idx) << 2);
  endfunction

endpackage

// File: rtl/mailbox_monitor.sv
// Watches the CPU store bus during RUN: captures result-slot writes, tracks
// which slots were hit, spots the done-flag store and forms the verdict.
module mailbox_monitor
  import riscv_tb_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_ARGS  = 2,
  parameter int          NUM_RES   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      mem_write,
  input  logic [31:0]               data_adr,
  input  logic [DATA_W-1:0]         write_data,
  input  logic [NUM_RES*DATA_W-1:0] exp_data,
  output logic                      done_seen,
  output logic [1:0]                verdict
);

  localparam logic [31:0] DONE_ADR = mbox_addr(BASE_ADDR, NUM_ARGS + NUM_RES);

  logic [NUM_RES-1:0]        hit;
  logic [NUM_RES*DATA_W-1:0] cap;
  logic                      any_miss;
  logic                      any_bad;

  // Hit flags: one per result slot, set on any store to that slot.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hit <= '0;
    end else if (en && mem_write) begin
      for (int j = 0; j < NUM_RES; j++) begin
        if (data_adr == mbox_addr(BASE_ADDR, NUM_ARGS + j)) hit[j] <= 1'b1;
      end
    end
  end

  // Captured result values; a later store to the same slot overwrites.
  always_ff @(posedge clk) begin
    if (clear) begin
      cap <= '0;
    end else if (en && mem_write) begin
      for (int j = 0; j < NUM_RES; j++) begin
        if (data_adr == mbox_addr(BASE_ADDR, NUM_ARGS + j))
          cap[j*DATA_W +: DATA_W] <= write_data;
      end
    end
  end

  // Done detection and verdict; a missing slot outranks a wrong value.
  always_comb begin
    done_seen = en && mem_write && (data_adr == DONE_ADR) &&
                (write_data == DATA_W'(1));
    any_miss  = ~&hit;
    any_bad   = 1'b0;
    for (int j = 0; j < NUM_RES; j++) begin
      if (cap[j*DATA_W +: DATA_W] != exp_data[j*DATA_W +: DATA_W]) any_bad = 1'b1;
    end
    if (any_miss)     verdict = FAIL_MISSING;
    else if (any_bad) verdict = FAIL_MISMATCH;
    else              verdict = FAIL_NONE;
  end

endmodule

// File: rtl/riscv_selfcheck_sequencer.sv
// Self-check sequencer: preloads the mailbox through the external memory
// port, releases the CPU, then waits for the done flag or a timeout.
module riscv_selfcheck_sequencer
  import riscv_tb_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          NUM_ARGS    = 2,
  parameter int          NUM_RES     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_ARGS*DATA_W-1:0] arg_data,
  input  logic [NUM_RES*DATA_W-1:0]  exp_data,
  output logic                       cpu_reset,
  output logic                       Ext_MemWrite,
  output logic [DATA_W-1:0]          Ext_WriteData,
  output logic [31:0]                Ext_DataAdr,
  input  logic                       MemWrite,
  input  logic [31:0]                DataAdr,
  input  logic [DATA_W-1:0]          WriteData,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 fail_code,
  output logic [31:0]                cycle_count
);

  // Words preloaded: arguments, zeroed result slots, zeroed done flag.
  localparam int W   = NUM_ARGS + NUM_RES + 1;
  localparam int K_W = 6;

  state_t                     state_q, state_d;
  logic [K_W-1:0]             k_q, k_d;
  logic                       restart;
  logic [NUM_ARGS*DATA_W-1:0] args_q;
  logic [NUM_RES*DATA_W-1:0]  exp_q;
  logic                       done_seen;
  logic [1:0]                 verdict;

  logic                       cpu_reset_d, ext_we_d, busy_d, done_d, pass_d;
  logic [DATA_W-1:0]          ext_wd_d;
  logic [31:0]                ext_adr_d, cnt_d;
  logic [1:0]                 fail_d;

  mailbox_monitor #(
    .DATA_W    (DATA_W),
    .NUM_ARGS  (NUM_ARGS),
    .NUM_RES   (NUM_RES),
    .BASE_ADDR (BASE_ADDR)
  ) u_monitor (
    .clk        (clk),
    .reset      (reset),
    .en         (state_q == ST_RUN),
    .clear      (restart),
    .mem_write  (MemWrite),
    .data_adr   (DataAdr),
    .write_data (WriteData),
    .exp_data   (exp_q),
    .done_seen  (done_seen),
    .verdict    (verdict)
  );

  // State and word-index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Test operands captured when a test begins.
  always_ff @(posedge clk) begin
    if (restart) begin
      args_q <= arg_data;
      exp_q  <= exp_data;
    end
  end

  // Next-state logic; start is honoured only from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    restart = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_LOAD_WR;
          k_d     = '0;
        end
      end
      ST_LOAD_WR:  state_d = ST_LOAD_GAP;
      ST_LOAD_GAP: begin
        if (k_q == K_W'(W - 1)) begin
          state_d = ST_RUN;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_LOAD_WR;
        end
      end
      ST_RUN: begin
        if (done_seen || (cycle_count == 32'(TIMEOUT_CYC - 1))) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    cpu_reset_d = (state_d != ST_RUN);
    busy_d      = (state_d == ST_LOAD_WR) || (state_d == ST_LOAD_GAP) || (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    ext_we_d    = (state_d == ST_LOAD_WR);
    ext_adr_d   = '0;
    ext_wd_d    = '0;
    if (state_d == ST_LOAD_WR) begin
      ext_adr_d = mbox_addr(BASE_ADDR, int'(k_d));
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (k_d == K_W'(i))
          ext_wd_d = restart ? arg_data[i*DATA_W +: DATA_W] : args_q[i*DATA_W +: DATA_W];
      end
    end
    pass_d = pass;
    fail_d = fail_code;
    if (restart) begin
      pass_d = 1'b0;
      fail_d = FAIL_NONE;
    end else if (state_q == ST_RUN && state_d == ST_DONE) begin
      fail_d = done_seen ? verdict : FAIL_TIMEOUT;
      pass_d = (fail_d == FAIL_NONE);
    end
    if (restart)               cnt_d = '0;
    else if (state_q == ST_RUN) cnt_d = cycle_count + 32'd1;
    else                       cnt_d = cycle_count;
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_reset     <= 1'b1;
      Ext_MemWrite  <= 1'b0;
      Ext_WriteData <= '0;
      Ext_DataAdr   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_code     <= FAIL_NONE;
      cycle_count   <= '0;
    end else begin
      cpu_reset     <= cpu_reset_d;
      Ext_MemWrite  <= ext_we_d;
      Ext_WriteData <= ext_wd_d;
      Ext_DataAdr   <= ext_adr_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      fail_code     <= fail_d;
      cycle_count   <= cnt_d;
    end
  end

endmodule

// File: doc/riscv_selfcheck_sequencer.md
# riscv_selfcheck_sequencer

Synthesizable self-check sequencer for the RV32I core's program tests. It sits beside `top_riscv_cpu_tutorial` and drives the external memory port to preload a mailbox of argument words, then zeroes the result slots and the done flag. It then releases the CPU from reset and monitors the CPU store bus. When the program writes its done flag, or when a timeout expires, it reports pass or fail and a failure code.

## Interface
Parameters:
- `DATA_W`, 32, data/bus width.
- `NUM_ARGS`, 2, argument words preloaded; range 1..16.
- `NUM_RES`, 1, result words checked; range 1..16.
- `BASE_ADDR`, 32'h0200_0000, mailbox base. Mailbox layout:
  - arg i at BASE+4i;
  - result j at BASE+4(NUM_ARGS+j);
  - done flag at BASE+4(NUM_ARGS+NUM_RES).
- `TIMEOUT_CYC`, 100000, maximum RUN cycles before fail.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a test.
- `arg_data` in NUM_ARGS*DATA_W: argument words; word i is at [i*DATA_W +: DATA_W]. Latched at `start`.
- `exp_data` in NUM_RES*DATA_W: expected results, same packing. Latched at `start`.
- `cpu_reset` out 1: drives the CPU `reset`.
- `Ext_MemWrite` out 1, `Ext_WriteData` out DATA_W, `Ext_DataAdr` out 32: preload port to the CPU memory.
- `MemWrite` in 1, `DataAdr` in 32, `WriteData` in DATA_W: CPU store bus (observed only).
- `busy` out 1: high in LOAD/RUN.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done`.
- `fail_code` out 2: valid while `done`. 0 = ok, 1 = mismatch, 2 = missing result, 3 = timeout.
- `cycle_count` out 32: RUN cycles elapsed; frozen in DONE.

## Operation
- States: IDLE, LOAD_WR, LOAD_GAP, RUN, DONE.
- IDLE: `cpu_reset`=1, Ext outputs 0. `start` latches `arg_data`/`exp_data`, clears word index k, hit flags and captures, then goes to LOAD_WR.
- Preload word count W = NUM_ARGS+NUM_RES+1.
  - Word k<NUM_ARGS is arg k.
  - The remaining words are 0 (result slots, then done flag).
- LOAD_WR: `Ext_MemWrite`=1, `Ext_DataAdr`=BASE+4k, `Ext_WriteData`=word k. Always goes to LOAD_GAP.
- LOAD_GAP: Ext outputs 0. If k=W-1, go to RUN; else k++ and go to LOAD_WR.
- RUN: `cpu_reset`=0; `cycle_count` increments each cycle. When `MemWrite`=1:
  - `DataAdr` = result slot j: capture `WriteData` and set hit[j]. On repeated writes, the last value wins.
  - `DataAdr` = done address and `WriteData`=1: go to DONE with a verdict:
    - fail 2 if any hit[j]=0;
    - else fail 1 if any capture≠expected;
    - else pass.
  - Done-address writes of other values are ignored.
  - Stores to any other address are ignored.
- Timeout: `cycle_count`=TIMEOUT_CYC-1 without a done write → DONE, fail 3.
  - A done write in that same cycle wins over the timeout.
- DONE: `cpu_reset`=1; outputs are held. `start` restarts the test, with the same clearing as from IDLE.
- `start` in LOAD/RUN is ignored.
- `reset` at any time, including mid-load or mid-run, forces IDLE next edge and abandons the test. No further Ext writes occur.

## Timing
- Reset values:
  - `cpu_reset`=1;
  - all other outputs 0: `Ext_MemWrite`, `Ext_WriteData`, `Ext_DataAdr`, `busy`, `done`, `pass`, `fail_code`, `cycle_count`.
- All outputs are registered.
- `start` sampled at edge 0:
  - first Ext write is visible in cycle 1;
  - preload occupies cycles 1..2W, alternating write/gap;
  - `cpu_reset` falls in cycle 2W+1.
- The CPU store bus is sampled at the rising edge. `done`/`pass`/`fail_code` are valid from the cycle after the done store is sampled.
- `cycle_count` equals the number of RUN cycles, including the terminating cycle.

## Structure
- Package `riscv_tb_pkg`:
  - state enum;
  - fail-code constants (FAIL_NONE, FAIL_MISMATCH, FAIL_MISSING, FAIL_TIMEOUT);
  - function `mbox_addr(base, idx)`, which returns base+4*idx.
- Sub-module `mailbox_monitor`:
  - holds the RUN-phase decode, capture registers, hit flags and verdict logic;
  - inputs: store bus, enable, clear;
  - outputs: done_seen, verdict.
- The top holds the FSM, preload mux and timeout counter.

## Test plan
- Sum-of-N: NUM_ARGS=1, NUM_RES=1, arg 20, exp 210.
  - Check preload: writes at 0x02000000=20, 0x02000004=0, 0x02000008=0, one per two cycles.
  - Bus model stores 210 then done=1 → `pass`=1, `fail_code`=0.
- Mismatch: same setup, model stores 209 then done=1 → `pass`=0, `fail_code`=1.
- Missing result: NUM_RES=2.
  - Model writes only slot 0 (correct) then done=1 → `fail_code`=2.
  - Separately, slot 0 written 5 then 210, then done=1 → pass (last value wins).
- Timeout: TIMEOUT_CYC=50, model never writes done.
  - `done` rises exactly 50 cycles after `cpu_reset` falls, with `fail_code`=3 and `cycle_count`=50.
  - Variant: done write on the 50th RUN cycle → pass.
- Reset mid-load: assert `reset` during the 2nd LOAD_WR.
  - Next cycle, all outputs are at reset values and `cpu_reset`=1.
  - No further Ext writes occur.
  - A later `start` reloads from k=0.
- Restart/ignore: `start` pulsed during RUN has no effect. `start` in DONE clears `done`/`pass`/`cycle_count` and repeats the preload.
